tuart_cmd_ctrl: RTL and testbench

Command-level controller sitting between the Tiny-UART receiver and the LogIP core. It generates the receiver's oversampling strobe, collects received bytes, and frames them into SUMP-style commands: a single-byte short command, or a long command of one opcode plus four data bytes. Completed commands are handed to the core over a valid/ready handshake. Malformed or stalled traffic is flagged and discarded.

---
 rtl/logip_pkg.sv | 30 +++
 rtl/tuart_smpl_gen.sv | 32 +++
 rtl/tuart_cmd_ctrl.sv | 140 ++++++++++++++
 tb/tb_tuart_cmd_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/logip_pkg.sv
// logip_pkg: types and constants shared by the Tiny-UART / LogIP blocks.
//   opcode_t       - 8-bit command opcode
//   cmd_t          - {opcode, data[31:0]}, 40 bits packed
//   err_code_e     - receive-side error causes
//   LONG_CMD_BYTES - data bytes following a long-command opcode
//   smpl_div()     - oversampling divider, floor(clk/(baud*os)), at least 1
package logip_pkg;

  typedef logic [7:0] opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OVERRUN = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

  localparam int LONG_CMD_BYTES = 4;

  function automatic int smpl_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/tuart_smpl_gen.sv
// tuart_smpl_gen: free-running divider producing a one-cycle strobe every
// DIV clocks. Shared between the UART receiver and transmitter paths.
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   smpl - registered strobe, high one cycle per DIV cycles
module tuart_smpl_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic smpl
);

  // Keep a 1-bit counter when DIV==1 so the vector never collapses to zero width.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      smpl <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      smpl <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      smpl <= 1'b0;
    end
  end

endmodule

// File: rtl/tuart_cmd_ctrl.sv
// tuart_cmd_ctrl: frames bytes from the Tiny-UART receiver into SUMP-style
// commands for the LogIP core and generates the receiver's sample strobe.
//   Short command: one byte with bit7==0, data reported as zero.
//   Long command : opcode with bit7==1, then four data bytes, little-endian.
// Ports:
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   smpl_o                - oversampling strobe to the receiver
//   byte_i, byte_vld_i    - received byte and its one-cycle qualifier
//   cmd_o, cmd_vld_o,
//   cmd_rdy_i             - {opcode, data} to the core, valid/ready handshake
//   err_o, err_code_o     - one-cycle error pulse, sticky cause (err_code_e)
// Optional feature: define LOGIP_RX_TIMEOUT_EN to abandon a long command when
// the gap between its bytes reaches TIMEOUT_CYCLES (error code 2). Without it
// COLLECT waits indefinitely.
module tuart_cmd_ctrl
  import logip_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 115_200,
  parameter int OVERSAMPLE     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        smpl_o,
  input  logic [7:0]  byte_i,
  input  logic        byte_vld_i,
  output logic [39:0] cmd_o,
  output logic        cmd_vld_o,
  input  logic        cmd_rdy_i,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int DIV = smpl_div(CLK_FREQ, BAUD, OVERSAMPLE);

  tuart_smpl_gen #(.DIV(DIV)) u_smpl (
    .clk  (clk_i),
    .rst  (rst_i),
    .smpl (smpl_o)
  );

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;

  state_e    state;
  cmd_t      cmd;
  logic      cmd_vld;
  logic      err;
  err_code_e err_code;
  logic [1:0] idx;

`ifdef LOGIP_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  // Expiry is taken on the edge where the idle count would reach
  // TIMEOUT_CYCLES, so err_o rises exactly TIMEOUT_CYCLES cycles after the
  // last byte; the counter is cleared there and never actually wraps.
  wire tmo = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cmd      <= '0;
      cmd_vld  <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      idx      <= '0;
`ifdef LOGIP_RX_TIMEOUT_EN
      tcnt     <= '0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (byte_vld_i) begin
            cmd.opcode <= byte_i;
            cmd.data   <= '0;
            if (byte_i[7]) begin
              idx   <= '0;
`ifdef LOGIP_RX_TIMEOUT_EN
              tcnt  <= '0;
`endif
              state <= COLLECT;
            end else begin
              cmd_vld <= 1'b1;
              state   <= HOLD;
            end
          end
        end

        COLLECT: begin
          if (byte_vld_i) begin
            cmd.data[8*idx +: 8] <= byte_i;
            idx <= idx + 2'd1;   // wraps to 0 after the last byte
`ifdef LOGIP_RX_TIMEOUT_EN
            tcnt <= '0;
`endif
            if (idx == 2'(LONG_CMD_BYTES - 1)) begin
              cmd_vld <= 1'b1;
              state   <= HOLD;
            end
          end
`ifdef LOGIP_RX_TIMEOUT_EN
          else if (tmo) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            cmd      <= '0;
            idx      <= '0;
            tcnt     <= '0;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end

        HOLD: begin
          // A byte here is lost even if the core takes the command this cycle.
          if (byte_vld_i) begin
            err      <= 1'b1;
            err_code <= ERR_OVERRUN;
          end
          if (cmd_rdy_i) begin
            cmd_vld <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_o      = cmd;
  assign cmd_vld_o  = cmd_vld;
  assign err_o      = err;
  assign err_code_o = err_code;

endmodule

// File: tb/tb_tuart_cmd_ctrl.sv
module tb_tuart_cmd_ctrl;

  logic        clk;
  logic        rst;
  logic        smpl;
  logic [7:0]  byte_d;
  logic        byte_vld;
  logic [39:0] cmd;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        err;
  logic [1:0]  err_code;

  int n_cmp;
  int n_bad;

  tuart_cmd_ctrl #(
    .CLK_FREQ      (16_000_000),
    .BAUD          (100_000),
    .OVERSAMPLE    (16),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .smpl_o     (smpl),
    .byte_i     (byte_d),
    .byte_vld_i (byte_vld),
    .cmd_o      (cmd),
    .cmd_vld_o  (cmd_vld),
    .cmd_rdy_i  (cmd_rdy),
    .err_o      (err),
    .err_code_o (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one byte for one cycle; returns at the negedge after the capturing edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_d   = b;
    byte_vld = 1'b1;
    @(negedge clk);
    byte_vld = 1'b0;
  endtask

  // One-cycle ready pulse; returns at the negedge after the transfer edge.
  task automatic accept();
    @(negedge clk);
    cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; byte_d = '0; byte_vld = 1'b0; cmd_rdy = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (smpl !== 1'b0) begin n_bad++; $display("FAIL reset_smpl got %b want 0", smpl); end
    n_cmp++; if (cmd !== 40'h0) begin n_bad++; $display("FAIL reset_cmd got %h want 0", cmd); end
    n_cmp++; if (cmd_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", cmd_vld); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (err_code !== 2'd0) begin n_bad++; $display("FAIL reset_code got %0d want 0", err_code); end
    rst = 1'b0;
  endtask

  task automatic test_strobe();
    int gap;
    gap = 0;
    while (smpl !== 1'b1 && gap < 30) begin @(negedge clk); gap++; end
    n_cmp++; if (smpl !== 1'b1) begin n_bad++; $display("FAIL strobe_first got %b want 1 within 30 cycles", smpl); end
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      n_cmp++; if (smpl !== 1'b0) begin n_bad++; $display("FAIL strobe_width got %b want 0", smpl); end
      gap = 1;
      while (smpl !== 1'b1 && gap < 20) begin @(negedge clk); gap++; end
      n_cmp++; if (gap != 10) begin n_bad++; $display("FAIL strobe_period got %0d want 10", gap); end
    end
  endtask

  task automatic test_short();
    // ready while idle must not create or disturb anything
    accept();
    n_cmp++; if (cmd_vld !== 1'b0) begin n_bad++; $display("FAIL idle_rdy_vld got %b want 0", cmd_vld); end
    send_byte(8'h01);
    n_cmp++; if (cmd_vld !== 1'b1) begin n_bad++; $display("FAIL short_vld got %b want 1", cmd_vld); end
    n_cmp++; if (cmd !== 40'h01_00000000) begin n_bad++; $display("FAIL short_cmd got %h want 0100000000", cmd); end
    accept();
    n_cmp++; if (cmd_vld !== 1'b0) begin n_bad++; $display("FAIL short_drop got %b want 0", cmd_vld); end
  endtask

  task automatic test_long();
    int bad;
    send_byte(8'h80); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    n_cmp++; if (cmd_vld !== 1'b0) begin n_bad++; $display("FAIL long_early_vld got %b want 0", cmd_vld); end
    send_byte(8'h44);
    n_cmp++; if (cmd_vld !== 1'b1) begin n_bad++; $display("FAIL long_vld got %b want 1", cmd_vld); end
    n_cmp++; if (cmd !== 40'h80_44332211) begin n_bad++; $display("FAIL long_cmd got %h want 8044332211", cmd); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd !== 40'h80_44332211 || cmd_vld !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL long_hold unstable cycles got %0d want 0", bad); end
    accept();
    n_cmp++; if (cmd_vld !== 1'b0) begin n_bad++; $display("FAIL long_drop got %b want 0", cmd_vld); end
  endtask

  task automatic test_overrun();
    send_byte(8'h03);
    send_byte(8'h02);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovr_err got %b want 1", err); end
    n_cmp++; if (err_code !== 2'd1) begin n_bad++; $display("FAIL ovr_code got %0d want 1", err_code); end
    n_cmp++; if (cmd !== 40'h03_00000000 || cmd_vld !== 1'b1) begin n_bad++; $display("FAIL ovr_hold got %h/%b want 0300000000/1", cmd, cmd_vld); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ovr_pulse got %b want 0", err); end
    accept();
    n_cmp++; if (cmd_vld !== 1'b0) begin n_bad++; $display("FAIL ovr_drop got %b want 0", cmd_vld); end
    // byte coinciding with the transfer: dropped, flagged, never captured
    send_byte(8'h07);
    @(negedge clk);
    byte_d = 8'h0A; byte_vld = 1'b1; cmd_rdy = 1'b1;
    @(negedge clk);
    byte_vld = 1'b0; cmd_rdy = 1'b0;
    n_cmp++; if (cmd_vld !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL ovr_rdy vld/err got %b/%b want 0/1", cmd_vld, err); end
    @(negedge clk);
    n_cmp++; if (cmd_vld !== 1'b0 || cmd !== 40'h07_00000000) begin n_bad++; $display("FAIL ovr_nocap got %h/%b want 0700000000/0", cmd, cmd_vld); end
  endtask

  task automatic test_timeout();
    int bad;
    send_byte(8'hC0);
    send_byte(8'hAA);
    bad = 0;
`ifdef LOGIP_RX_TIMEOUT_EN
    for (int i = 1; i < 50; i++) begin
      @(negedge clk);
      if (err !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL tmo_early err cycles got %0d want 0", bad); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err got %b want 1", err); end
    n_cmp++; if (err_code !== 2'd2) begin n_bad++; $display("FAIL tmo_code got %0d want 2", err_code); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0 || cmd_vld !== 1'b0) begin n_bad++; $display("FAIL tmo_after err/vld got %b/%b want 0/0", err, cmd_vld); end
    send_byte(8'h01);
    n_cmp++; if (cmd_vld !== 1'b1 || cmd !== 40'h01_00000000) begin n_bad++; $display("FAIL tmo_next got %h/%b want 0100000000/1", cmd, cmd_vld); end
`else
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err !== 1'b0 || cmd_vld !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL notmo_idle bad cycles got %0d want 0", bad); end
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    n_cmp++; if (cmd_vld !== 1'b1 || cmd !== 40'hC0_DDCCBBAA) begin n_bad++; $display("FAIL notmo_cmd got %h/%b want C0DDCCBBAA/1", cmd, cmd_vld); end
    n_cmp++; if (err_code !== 2'd1) begin n_bad++; $display("FAIL notmo_code got %0d want 1", err_code); end
`endif
    accept();
    n_cmp++; if (cmd_vld !== 1'b0) begin n_bad++; $display("FAIL tmo_drop got %b want 0", cmd_vld); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h80); send_byte(8'h11); send_byte(8'h22);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (cmd !== 40'h0 || cmd_vld !== 1'b0) begin n_bad++; $display("FAIL rstmid_cmd got %h/%b want 0/0", cmd, cmd_vld); end
    n_cmp++; if (err !== 1'b0 || err_code !== 2'd0 || smpl !== 1'b0) begin n_bad++; $display("FAIL rstmid_err got %b/%0d/%b want 0/0/0", err, err_code, smpl); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_byte(8'h05);
    n_cmp++; if (cmd_vld !== 1'b1 || cmd !== 40'h05_00000000) begin n_bad++; $display("FAIL rstmid_fresh got %h/%b want 0500000000/1", cmd, cmd_vld); end
    accept();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_strobe();
    test_short();
    test_long();
    test_overrun();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
